// File: rtl/v_tile_tx.sv
// v_tile_tx: transmit side of the CGRA tile network port.
// Adder results are staged, buffered in a small FIFO, then delivered serially
// (lowest destination index first) using the write_en / write_ack handshake.
module v_tile_tx #(
  parameter int unsigned width      = 16,
  parameter int unsigned num_inputs = 4,
  parameter int unsigned num_dests  = 4,
  parameter int unsigned fifo_depth = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [width*num_inputs-1:0]   in_data,
  input  logic [3:0]                    in_dest,
  input  logic [num_dests-1:0]          write_rdy_i,
  input  logic [num_dests-1:0]          write_ack_i,
  output logic [num_dests-1:0]          write_en_o,
  output logic [width*num_inputs-1:0]   w_data_out,
  output logic                          busy,
  output logic                          overflow,
  output logic [15:0]                   sent_count
);

  localparam int unsigned DW = width * num_inputs;
  localparam int unsigned AW = $clog2(fifo_depth);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    SEND = 2'd2
  } state_e;

  // input staging register
  logic                 stg_vld_q;
  logic [DW-1:0]        stg_data_q;
  logic [num_dests-1:0] stg_mask_q;

  // result FIFO
  logic [DW-1:0]        mem_data_q [fifo_depth];
  logic [num_dests-1:0] mem_mask_q [fifo_depth];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 full, push, pop;
  logic [DW-1:0]        hd_data;
  logic [num_dests-1:0] hd_mask;

  // transfer FSM and registered outputs
  state_e               state_q, state_d;
  logic [DW-1:0]        hold_q, hold_d;
  logic [num_dests-1:0] mask_q, mask_d;
  logic [num_dests-1:0] en_q, en_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [15:0]          sent_q, sent_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q;
  logic [num_dests-1:0] sel_oh;

  assign full    = (cnt_q == CW'(fifo_depth));
  // Fullness is judged on the pre-pop count, so a same-cycle pop never frees a slot.
  assign push    = stg_vld_q && !full;
  assign hd_data = mem_data_q[rd_ptr_q];
  assign hd_mask = mem_mask_q[rd_ptr_q];
  // Isolate the lowest pending destination bit.
  assign sel_oh  = mask_q & (~mask_q + num_dests'(1));

  // Stage incoming results, write them into the FIFO, track pointers and overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_vld_q  <= 1'b0;
      stg_data_q <= '0;
      stg_mask_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      for (int unsigned i = 0; i < fifo_depth; i++) begin
        mem_data_q[i] <= '0;
        mem_mask_q[i] <= '0;
      end
    end else begin
      stg_vld_q  <= in_valid;
      stg_data_q <= in_data;
      stg_mask_q <= in_dest[num_dests-1:0];
      if (push) begin
        mem_data_q[wr_ptr_q] <= stg_data_q;
        mem_mask_q[wr_ptr_q] <= stg_mask_q;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (stg_vld_q && full) begin
        ovf_q <= 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      cnt_q <= cnt_d;
    end
  end

  // FIFO occupancy update.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // FSM state and registered output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      mask_q  <= '0;
      en_q    <= '0;
      wdata_q <= '0;
      sent_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      mask_q  <= mask_d;
      en_q    <= en_d;
      wdata_q <= wdata_d;
      sent_q  <= sent_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: pop, arbitrate lowest pending bit, hold request until ack.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    mask_d  = mask_q;
    en_d    = en_q;
    wdata_d = wdata_q;
    sent_d  = sent_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          hold_d  = hd_data;
          mask_d  = hd_mask;
          state_d = ARB;
        end
      end
      ARB: begin
        if (mask_q == '0) begin
          state_d = IDLE;
        end else if (|(write_rdy_i & sel_oh)) begin
          en_d    = sel_oh;
          wdata_d = hold_q;
          state_d = SEND;
        end
      end
      SEND: begin
        if (|(write_ack_i & en_q)) begin
          en_d    = '0;
          mask_d  = mask_q & ~en_q;
          sent_d  = sent_q + 16'd1;
          state_d = ARB;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (cnt_d != '0) || (state_d != IDLE);
  end

  assign write_en_o = en_q;
  assign w_data_out = wdata_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
  assign sent_count = sent_q;

endmodule

// File: tb/tb_v_tile_tx.sv
// Scoreboard bench for v_tile_tx: stimulus pushes expected transfers, a monitor
// pops and compares on every new write request, a responder returns acks.
module tb_v_tile_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_data;
  logic [3:0]  in_dest;
  logic [3:0]  rdy;
  logic [3:0]  ack_r;
  logic [3:0]  stray;
  logic [3:0]  en;
  logic [63:0] wdata;
  logic        busy;
  logic        ovf;
  logic [15:0] cnt;

  int total = 0;
  int bad   = 0;
  int ack_dly = 2;
  int wait_cnt = 0;

  logic [3:0]  exp_port_q [$];
  logic [63:0] exp_data_q [$];
  logic [3:0]  prev_en = '0;
  logic [63:0] prev_data = '0;

  v_tile_tx #(
    .width      (16),
    .num_inputs (4),
    .num_dests  (4),
    .fifo_depth (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_dest     (in_dest),
    .write_rdy_i (rdy),
    .write_ack_i (ack_r | stray),
    .write_en_o  (en),
    .w_data_out  (wdata),
    .busy        (busy),
    .overflow    (ovf),
    .sent_count  (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_xfer(input logic [3:0] port, input logic [63:0] data);
    exp_port_q.push_back(port);
    exp_data_q.push_back(data);
  endtask

  task automatic send(input logic [3:0] dest, input logic [63:0] data);
    in_valid = 1'b1;
    in_dest  = dest;
    in_data  = data;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    repeat (3) @(negedge clk);
    for (i = 0; i < 400; i++) begin
      if (busy == 1'b0 && en == '0 && exp_port_q.size() == 0) break;
      @(negedge clk);
    end
    if (i == 400) chk("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic wait_en();
    int i;
    for (i = 0; i < 50; i++) begin
      if (en != '0) break;
      @(negedge clk);
    end
    chk("en_wait", {63'd0, (en != '0)}, 64'd1);
  endtask

  // Monitor: every new write request must match the scoreboard head; an active
  // request must hold port and data until it drops.
  always @(negedge clk) begin
    if (reset && en != '0 && prev_en == '0) begin
      if (exp_port_q.size() == 0) begin
        chk("unexpected_xfer", {60'd0, en}, 64'd0);
      end else begin
        chk("xfer_port", {60'd0, en}, {60'd0, exp_port_q.pop_front()});
        chk("xfer_data", wdata, exp_data_q.pop_front());
        chk("xfer_onehot", 64'($countones(en)), 64'd1);
      end
    end else if (en != '0 && prev_en != '0) begin
      chk("en_hold", {60'd0, en}, {60'd0, prev_en});
      chk("data_hold", wdata, prev_data);
    end
    prev_en   = en;
    prev_data = wdata;
  end

  // Responder: acknowledge the active port after ack_dly cycles.
  always @(negedge clk) begin
    if (en != '0 && ack_r == '0) begin
      if (wait_cnt >= ack_dly) begin
        ack_r    = en;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      ack_r    = '0;
      wait_cnt = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] V1 = 64'h0001_0002_0003_0004;
  localparam logic [63:0] V2 = 64'hA5A5_0F0F_1234_FFFF;
  localparam logic [63:0] V3 = 64'h0000_1111_2222_3333;
  localparam logic [63:0] V5 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] VT [6] = '{
    64'h0011_0012_0013_0014, 64'h0021_0022_0023_0024, 64'h0031_0032_0033_0034,
    64'h0041_0042_0043_0044, 64'h0051_0052_0053_0054, 64'h0061_0062_0063_0064
  };

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_dest  = '0;
    rdy      = 4'b1111;
    ack_r    = '0;
    stray    = '0;
    repeat (3) @(negedge clk);
    chk("rst_en",    {60'd0, en}, 64'd0);
    chk("rst_data",  wdata, 64'd0);
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_ovf",   {63'd0, ovf}, 64'd0);
    chk("rst_count", {48'd0, cnt}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1: single destination, latency and ack after 2 cycles
    ack_dly = 2;
    expect_xfer(4'b0001, V1);
    send(4'b0001, V1);
    chk("lat_n0", {60'd0, en}, 64'd0);
    @(negedge clk);
    chk("lat_n1", {60'd0, en}, 64'd0);
    @(negedge clk);
    chk("lat_n2", {60'd0, en}, 64'd0);
    @(negedge clk);
    chk("lat_n3", {60'd0, en}, 64'd1);
    wait_idle();
    chk("t1_count", {48'd0, cnt}, 64'd1);
    chk("t1_busy", {63'd0, busy}, 64'd0);

    // 2: multicast to ports 1 and 3, serial lowest first
    expect_xfer(4'b0010, V2);
    expect_xfer(4'b1000, V2);
    send(4'b1010, V2);
    wait_idle();
    chk("t2_count", {48'd0, cnt}, 64'd3);

    // 3: destination not ready waits in arbitration; ack/rdy changes handled
    ack_dly = 4;
    rdy = 4'b1110;
    expect_xfer(4'b0001, V3);
    send(4'b0001, V3);
    for (int i = 0; i < 10; i++) begin
      stray = (i == 5) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      chk("t3_wait_en", {60'd0, en}, 64'd0);
    end
    stray = '0;
    chk("t3_busy", {63'd0, busy}, 64'd1);
    chk("t3_stray_count", {48'd0, cnt}, 64'd3);
    rdy = 4'b1111;
    @(negedge clk);
    chk("t3_rise", {60'd0, en}, 64'd1);
    rdy   = 4'b0000;
    stray = 4'b0010;
    @(negedge clk);
    stray = '0;
    chk("t3_hold1", {60'd0, en}, 64'd1);
    @(negedge clk);
    chk("t3_hold2", {60'd0, en}, 64'd1);
    rdy = 4'b1111;
    wait_idle();
    chk("t3_count", {48'd0, cnt}, 64'd4);

    // 4: six back-to-back results with nothing ready; the first sits in the
    // holding register, four fill the FIFO, the sixth is dropped
    ack_dly = 1;
    rdy = 4'b0000;
    for (int k = 0; k < 5; k++) expect_xfer(4'b0001, VT[k]);
    for (int k = 0; k < 6; k++) send(4'b0001, VT[k]);
    chk("t4_ovf_early", {63'd0, ovf}, 64'd0);
    @(negedge clk);
    chk("t4_ovf", {63'd0, ovf}, 64'd1);
    chk("t4_busy", {63'd0, busy}, 64'd1);
    rdy = 4'b1111;
    wait_idle();
    chk("t4_count", {48'd0, cnt}, 64'd9);
    chk("t4_ovf_sticky", {63'd0, ovf}, 64'd1);

    // 5: asynchronous reset in the middle of a transfer
    ack_dly = 20;
    expect_xfer(4'b0001, V5);
    send(4'b0001, V5);
    wait_en();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t5_en",    {60'd0, en}, 64'd0);
    chk("t5_busy",  {63'd0, busy}, 64'd0);
    chk("t5_count", {48'd0, cnt}, 64'd0);
    chk("t5_ovf",   {63'd0, ovf}, 64'd0);
    chk("t5_data",  wdata, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b1;
    ack_dly = 2;
    @(negedge clk);
    send(4'b0000, V1);
    @(negedge clk);
    chk("t5_zero_busy", {63'd0, busy}, 64'd1);
    wait_idle();
    chk("t5_zero_count", {48'd0, cnt}, 64'd0);
    chk("t5_zero_en", {60'd0, en}, 64'd0);

    chk("sb_left", 64'(exp_port_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
